// File: rtl/clause_formula_loader.sv
// Writer side of the clause-setup protocol: streams host clause words into the
// proposer's clause register, latches the assignment, then enables reduction.
module clause_formula_loader #(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 4,
  parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 1,
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   = 4,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 2,
  parameter int SETTLE_CYCLES                       = 2,
  localparam int VN  = 2 ** MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX,
  localparam int CN  = 2 ** MAX_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int CW  = (VN + 1) * MAXIMUM_BIT_WIDTH_OF_COEFFICIENT,
  localparam int AW  = VN * MAX_BIT_WIDTH_OF_INTEGER_VARIABLE,
  localparam int CIW = MAX_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int NW  = MAX_BIT_WIDTH_OF_CLAUSES_INDEX + 1,
  localparam int IVW = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE
) (
  input  logic           in_clk,
  input  logic           in_reset,
  input  logic           in_start,
  input  logic [NW-1:0]  in_num_clauses,
  input  logic [AW-1:0]  in_integer_assignment,
  input  logic [IVW-1:0] in_variable_index,
  input  logic           in_clause_valid,
  input  logic [CW-1:0]  in_clause_data,
  output logic           out_clause_ready,
  input  logic           in_stop,
  output logic [CW-1:0]  out_clause_coefficients_integer,
  output logic [CIW-1:0] out_clause_index,
  output logic           out_clause_write,
  output logic [AW-1:0]  out_integer_assignment_before_move,
  output logic [IVW-1:0] out_variable_to_be_unchanced_index,
  output logic [CN-1:0]  out_reduce_enable,
  output logic           out_busy,
  output logic           out_loaded,
  output logic           out_error
);

  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_ACTIVE} state_t;

  state_t         state_q;
  logic [NW-1:0]  num_q;
  logic [CIW-1:0] cnt_q;
  logic [SW-1:0]  settle_q;
  logic [CW-1:0]  coef_q;
  logic [CIW-1:0] idx_q;
  logic           wr_q;
  logic [AW-1:0]  asg_q;
  logic [IVW-1:0] var_q;
  logic [CN-1:0]  en_q;
  logic           busy_q;
  logic           loaded_q;
  logic           err_q;
  logic           start_ok_d;
  logic           last_xfer_d;

  function automatic logic [CN-1:0] low_mask(input logic [NW-1:0] n);
    logic [CN:0] m;
    m = ((CN + 1)'(1) << n) - (CN + 1)'(1);
    return m[CN-1:0];
  endfunction

  assign start_ok_d  = (in_num_clauses != '0) && (in_num_clauses <= NW'(CN));
  assign last_xfer_d = ({1'b0, cnt_q} == (num_q - NW'(1)));

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      coef_q   <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      asg_q    <= '0;
      var_q    <= '0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_start) begin
            if (start_ok_d) begin
              num_q   <= in_num_clauses;
              asg_q   <= in_integer_assignment;
              var_q   <= in_variable_index;
              cnt_q   <= '0;
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        // Stop wins over a same-edge transfer; clauses already written stay put.
        S_LOAD: begin
          if (in_stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (in_clause_valid) begin
            coef_q <= in_clause_data;
            idx_q  <= cnt_q;
            wr_q   <= 1'b1;
            if (last_xfer_d) begin
              state_q  <= S_SETTLE;
              settle_q <= SW'(SETTLE_CYCLES);
            end else begin
              cnt_q <= cnt_q + CIW'(1);
            end
          end
        end
        S_SETTLE: begin
          if (in_stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (settle_q == '0) begin
            state_q  <= S_ACTIVE;
            en_q     <= low_mask(num_q);
            loaded_q <= 1'b1;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        S_ACTIVE: begin
          if (in_stop) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            en_q     <= '0;
            loaded_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_clause_ready                   = (state_q == S_LOAD);
  assign out_clause_coefficients_integer    = coef_q;
  assign out_clause_index                   = idx_q;
  assign out_clause_write                   = wr_q;
  assign out_integer_assignment_before_move = asg_q;
  assign out_variable_to_be_unchanced_index = var_q;
  assign out_reduce_enable                  = en_q;
  assign out_busy                           = busy_q;
  assign out_loaded                         = loaded_q;
  assign out_error                          = err_q;

endmodule
